// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and strobe bundle
// for the scan generator and its consumers.
package vga_timing_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam logic SYNC_ACT = 1'b0;

  localparam int CW = 10;
  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    hs:  ~SYNC_ACT,
    vs:  ~SYNC_ACT,
    act: 1'b0
  };

  function automatic logic in_win(
    input coord_t c,
    input int     lo,
    input int     n
  );
    return (c >= coord_t'(lo)) &&
           (c <  coord_t'(lo + n));
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator output bundle toward color_mapper,
// plus the pixel clock enable that paces it.
interface vga_scan_gen_if;
  import vga_timing_pkg::*;

  logic   pix_ce;
  coord_t DrawX;
  coord_t DrawY;
  logic   VGA_HS;
  logic   VGA_VS;
  logic   VGA_BLANK_N;
  logic   VGA_SYNC_N;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  pix_ce,
    output DrawX,
    output DrawY,
    output VGA_HS,
    output VGA_VS,
    output VGA_BLANK_N,
    output VGA_SYNC_N,
    output line_start,
    output frame_start
  );

  modport slave (
    output pix_ce,
    input  DrawX,
    input  DrawY,
    input  VGA_HS,
    input  VGA_VS,
    input  VGA_BLANK_N,
    input  VGA_SYNC_N,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of configurable depth;
// depth 0 is a plain wire.
module sync_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         en,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{Clk, Reset, en, rst_val};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stg [DEPTH];

    always_ff @(posedge Clk) begin
      if (Reset) begin
        for (int i = 0; i < DEPTH; i++)
          stg[i] <= rst_val;
      end else if (en) begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Pixel-scan counters, sync/blank decode and the
// strobe delay that aligns them with color_mapper RGB.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter int PIPE_DELAY = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  vga_scan_gen_if.master vga
);

  localparam coord_t H_LAST =
    coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST =
    coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  coord_t  hc;
  coord_t  vc;
  logic    h_wrap;
  logic    v_wrap;
  logic    line_q;
  logic    frame_q;
  strobe_t raw;
  strobe_t dly;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = h_wrap && (vc == V_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (vga.pix_ce) begin
      if (h_wrap) begin
        hc <= '0;
        vc <= v_wrap ? '0 : vc + coord_t'(1);
      end else begin
        hc <= hc + coord_t'(1);
      end
    end
  end

  // Pulses mark the cycle in which the counters show the wrap.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= vga.pix_ce && h_wrap;
      frame_q <= vga.pix_ce && v_wrap;
    end
  end

  always_comb begin
    raw     = STROBE_IDLE;
    raw.hs  = in_win(hc, H_ACTIVE + H_FP, H_SYNC) ?
              SYNC_ACT : ~SYNC_ACT;
    raw.vs  = in_win(vc, V_ACTIVE + V_FP, V_SYNC) ?
              SYNC_ACT : ~SYNC_ACT;
    raw.act = (hc < coord_t'(H_ACTIVE)) &&
              (vc < coord_t'(V_ACTIVE));
  end

  sync_delay_line #(
    .W     ($bits(strobe_t)),
    .DEPTH (PIPE_DELAY)
  ) u_dly (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (vga.pix_ce),
    .rst_val (STROBE_IDLE),
    .d       (raw),
    .q       (dly)
  );

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.VGA_HS      = dly.hs;
  assign vga.VGA_VS      = dly.vs;
  assign vga.VGA_BLANK_N = dly.act;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule
